// File: rtl/reset_pulse_monitor.sv
// Synchronizes an observed reset line, emits assert/deassert events and checks pulse widths.
// Optional glitch filter on the synchronized line is enabled by defining RESET_MON_FILTER_EN.
module reset_pulse_monitor #(
    parameter bit          RESET_POLARITY = 1'b1,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned FILTER_CYCLES  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mon_reset,
    input  logic [CNT_WIDTH-1:0] cfg_min_active,
    input  logic [CNT_WIDTH-1:0] cfg_max_active,
    input  logic                 clear_stats,
    output logic                 in_reset,
    output logic                 assert_pulse,
    output logic                 deassert_pulse,
    output logic [CNT_WIDTH-1:0] active_len,
    output logic                 active_len_valid,
    output logic [7:0]           assert_count,
    output logic                 err_short,
    output logic                 err_long
);

    localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("reset_pulse_monitor: SYNC_STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("reset_pulse_monitor: FILTER_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {StInit, StIdle, StActive} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   act;
    logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   active_len_q, active_len_d;
    logic [7:0]             count_q, count_d, count_base;
    logic                   assert_q, assert_d;
    logic                   deassert_q, deassert_d;
    logic                   len_valid_q, len_valid_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;

    // Flops start at the inactive level so no spurious event appears out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{~RESET_POLARITY}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_reset};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef RESET_MON_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);

    logic [FILT_W-1:0] filt_cnt_q;
    logic              filt_level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_cnt_q   <= '0;
            filt_level_q <= ~RESET_POLARITY;
        end else if (sync_out != filt_level_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_CYCLES - 1)) begin
                filt_level_q <= sync_out;
                filt_cnt_q   <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    assign act = (filt_level_q == RESET_POLARITY);
`else
    assign act = (sync_out == RESET_POLARITY);
`endif

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        cnt_d        = cnt_q;
        active_len_d = active_len_q;
        assert_d     = 1'b0;
        deassert_d   = 1'b0;
        len_valid_d  = 1'b0;
        // Clear forms the base value so a same-cycle update still lands on top of it.
        count_base   = clear_stats ? 8'd0 : count_q;
        count_d      = count_base;
        err_short_d  = clear_stats ? 1'b0 : err_short_q;
        err_long_d   = clear_stats ? 1'b0 : err_long_q;

        unique case (state_q)
            StInit: begin
                if (init_cnt_q == INIT_W'(SYNC_STAGES)) begin
                    if (act) begin
                        state_d  = StActive;
                        assert_d = 1'b1;
                        cnt_d    = CNT_WIDTH'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (act) begin
                    state_d  = StActive;
                    assert_d = 1'b1;
                    cnt_d    = CNT_WIDTH'(1);
                end
            end
            StActive: begin
                if (act) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cfg_max_active != '0 && cnt_d > cfg_max_active) begin
                        err_long_d = 1'b1;
                    end
                end else begin
                    state_d      = StIdle;
                    deassert_d   = 1'b1;
                    len_valid_d  = 1'b1;
                    active_len_d = cnt_q;
                    count_d      = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
                    if (cnt_q < cfg_min_active) begin
                        err_short_d = 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            cnt_q        <= '0;
            active_len_q <= '0;
            count_q      <= '0;
            assert_q     <= 1'b0;
            deassert_q   <= 1'b0;
            len_valid_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            cnt_q        <= cnt_d;
            active_len_q <= active_len_d;
            count_q      <= count_d;
            assert_q     <= assert_d;
            deassert_q   <= deassert_d;
            len_valid_q  <= len_valid_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign in_reset         = (state_q == StActive);
    assign assert_pulse     = assert_q;
    assign deassert_pulse   = deassert_q;
    assign active_len       = active_len_q;
    assign active_len_valid = len_valid_q;
    assign assert_count     = count_q;
    assign err_short        = err_short_q;
    assign err_long         = err_long_q;

endmodule

// File: tb/tb_reset_pulse_monitor.sv
// Scoreboard bench: an active-high 16-bit monitor and an active-low 4-bit monitor watch the
// same reset line; expected events are queued by the stimulus and popped by a monitor process.
module tb_reset_pulse_monitor;

    localparam int S = 2;
`ifdef RESET_MON_FILTER_EN
    localparam int F = 3;
`else
    localparam int F = 0;
`endif
    localparam int LAT = S + 1 + F;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mon_reset = 1'b0;
    logic        mon_reset_n;
    logic        clear_stats = 1'b0;
    logic [15:0] cfg_min = 16'd4;
    logic [15:0] cfg_max = 16'd0;
    logic [3:0]  cfg_min2 = 4'd4;
    logic [3:0]  cfg_max2 = 4'd0;

    logic        in_reset, assert_pulse, deassert_pulse, active_len_valid, err_short, err_long;
    logic [15:0] active_len;
    logic [7:0]  assert_count;
    logic        in_reset2, assert_pulse2, deassert_pulse2, active_len_valid2;
    logic        err_short2, err_long2;
    logic [3:0]  active_len2;
    logic [7:0]  assert_count2;

    assign mon_reset_n = ~mon_reset;

    reset_pulse_monitor #(
        .RESET_POLARITY(1'b1), .SYNC_STAGES(S), .CNT_WIDTH(16), .FILTER_CYCLES(3)
    ) u_dut (
        .clock(clock), .reset(reset), .mon_reset(mon_reset),
        .cfg_min_active(cfg_min), .cfg_max_active(cfg_max), .clear_stats(clear_stats),
        .in_reset(in_reset), .assert_pulse(assert_pulse), .deassert_pulse(deassert_pulse),
        .active_len(active_len), .active_len_valid(active_len_valid),
        .assert_count(assert_count), .err_short(err_short), .err_long(err_long)
    );

    reset_pulse_monitor #(
        .RESET_POLARITY(1'b0), .SYNC_STAGES(S), .CNT_WIDTH(4), .FILTER_CYCLES(3)
    ) u_dut_lo (
        .clock(clock), .reset(reset), .mon_reset(mon_reset_n),
        .cfg_min_active(cfg_min2), .cfg_max_active(cfg_max2), .clear_stats(clear_stats),
        .in_reset(in_reset2), .assert_pulse(assert_pulse2), .deassert_pulse(deassert_pulse2),
        .active_len(active_len2), .active_len_valid(active_len_valid2),
        .assert_count(assert_count2), .err_short(err_short2), .err_long(err_long2)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int len;
        bit es;
        bit el;
        int cnt;
    } exp_t;

    exp_t q_deas[$];
    exp_t q_deas2[$];
    int   q_as[$];
    int   q_as2[$];
    int   q_el[$];

    int checks = 0;
    int errors = 0;

    int m_count = 0, m_count2 = 0;
    bit m_es = 0, m_el = 0, m_es2 = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic model_clear();
        m_count = 0; m_count2 = 0;
        m_es = 0; m_el = 0; m_es2 = 0;
    endtask

    // Drive an active pulse of n cycles; clr raises clear_stats on the deassert-event edge.
    task automatic pulse(input int n, input bit clr);
        int  c;
        bit  seen;
        c = cyc;
        seen = (F == 0) || (n >= F);
        mon_reset = 1'b1;
        if (seen) begin
            q_as.push_back(c + LAT);
            q_as2.push_back(c + LAT);
            if (cfg_max != 0 && n > int'(cfg_max) && !m_el) q_el.push_back(c + LAT + int'(cfg_max));
        end
        tick(n);
        mon_reset = 1'b0;
        if (seen) begin
            if (clr) model_clear();
            if (n < int'(cfg_min)) m_es = 1;
            if (cfg_max != 0 && n > int'(cfg_max)) m_el = 1;
            if (m_count < 255) m_count++;
            q_deas.push_back('{c + n + LAT, n, m_es, m_el, m_count});
            if (n < 4) m_es2 = 1;
            if (m_count2 < 255) m_count2++;
            q_deas2.push_back('{c + n + LAT, (n > 15) ? 15 : n, m_es2, 1'b0, m_count2});
        end
        if (clr) begin
            tick(LAT - 1);
            clear_stats = 1'b1;
            tick(1);
            clear_stats = 1'b0;
        end
    endtask

    logic el_prev = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (assert_pulse) begin
            if (q_as.size() == 0) chk("assert_unexpected", 1, 0);
            else chk("assert_cycle", cyc, q_as.pop_front());
        end
        if (active_len_valid || deassert_pulse) begin
            if (q_deas.size() == 0) begin
                chk("deassert_unexpected", 1, 0);
            end else begin
                e = q_deas.pop_front();
                chk("deassert_cycle", cyc, e.cyc);
                chk("deassert_pulse", deassert_pulse, 1);
                chk("len_valid", active_len_valid, 1);
                chk("active_len", active_len, e.len);
                chk("err_short", err_short, e.es);
                chk("err_long", err_long, e.el);
                chk("assert_count", assert_count, e.cnt);
            end
        end
        if (err_long && !el_prev) begin
            if (q_el.size() == 0) chk("err_long_unexpected", 1, 0);
            else chk("err_long_cycle", cyc, q_el.pop_front());
        end
        el_prev = err_long;
        if (assert_pulse2) begin
            if (q_as2.size() == 0) chk("lo_assert_unexpected", 1, 0);
            else chk("lo_assert_cycle", cyc, q_as2.pop_front());
        end
        if (active_len_valid2 || deassert_pulse2) begin
            if (q_deas2.size() == 0) begin
                chk("lo_deassert_unexpected", 1, 0);
            end else begin
                e = q_deas2.pop_front();
                chk("lo_deassert_cycle", cyc, e.cyc);
                chk("lo_deassert_pulse", deassert_pulse2, 1);
                chk("lo_len_valid", active_len_valid2, 1);
                chk("lo_active_len", active_len2, e.len);
                chk("lo_err_short", err_short2, e.es);
                chk("lo_err_long", err_long2, e.el);
                chk("lo_assert_count", assert_count2, e.cnt);
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_in_reset"}, in_reset, 0);
        chk({tag, "_count"}, assert_count, 0);
        chk({tag, "_err_short"}, err_short, 0);
        chk({tag, "_err_long"}, err_long, 0);
        chk({tag, "_lo_in_reset"}, in_reset2, 0);
        chk({tag, "_lo_count"}, assert_count2, 0);
        chk({tag, "_lo_err_short"}, err_short2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick(3);
        check_idle("rst");
        chk("rst_active_len", active_len, 0);
        chk("rst_assert_pulse", assert_pulse, 0);
        chk("rst_len_valid", active_len_valid, 0);
        chk("rst_lo_active_len", active_len2, 0);

        // Power-up: observed reset already active as the monitor leaves reset.
        reset = 1'b0;
        pulse(20, 1'b0);
        tick(LAT + 4);
        pulse(10, 1'b0);
        tick(LAT + 4);
        pulse(2, 1'b0);
        tick(LAT + 4);
        chk("short_flag_held", err_short, m_es);

        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        model_clear();
        chk("clr_err_short", err_short, 0);
        chk("clr_count", assert_count, 0);
        chk("clr_lo_count", assert_count2, 0);

        cfg_max = 16'd5;
        pulse(8, 1'b0);
        tick(LAT + 4);
        cfg_max = 16'd0;
        pulse(40, 1'b0);
        tick(LAT + 4);
        pulse(10, 1'b0);
        tick(LAT + 4);
        pulse(3, 1'b1);
        tick(LAT + 4);

        // Monitor reset in the middle of a pulse discards it silently.
        mon_reset = 1'b1;
        q_as.push_back(cyc + LAT);
        q_as2.push_back(cyc + LAT);
        tick(LAT + 6);
        reset = 1'b1;
        tick(1);
        model_clear();
        check_idle("midrst");
        mon_reset = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(LAT + 6);
        check_idle("post");

        chk("q_assert_empty", q_as.size(), 0);
        chk("q_deassert_empty", q_deas.size(), 0);
        chk("q_err_long_empty", q_el.size(), 0);
        chk("q_lo_assert_empty", q_as2.size(), 0);
        chk("q_lo_deassert_empty", q_deas2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
